// File: rtl/bram_resp_pkg.sv
// Shared types and constants for the BRAM responder and its arbiter.
package bram_resp_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;

  // Port-select encoding, used for grants and for the last-grant flag
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_VID = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. On a tie, the port that was not
// granted last time wins. last_grant moves only on the update strobe.
module rr_arbiter2
  import bram_resp_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_cpu,
  input  logic req_vid,
  input  logic update,
  input  logic upd_port,
  output logic grant_valid,
  output logic grant_port
);

  logic last_grant;

  // Grant decision: a single requester wins outright, ties alternate
  always_comb begin
    grant_valid = req_cpu | req_vid;
    grant_port  = PORT_CPU;
    if (req_cpu && req_vid) begin
      grant_port = (last_grant == PORT_VID) ? PORT_CPU : PORT_VID;
    end else if (req_vid) begin
      grant_port = PORT_VID;
    end
  end

  // Last-grant flag; reset to video so the CPU wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= PORT_VID;
    end else if (update) begin
      last_grant <= upd_port;
    end
  end

endmodule

// File: rtl/bram_responder.sv
// Services CPU load/store and display read requests through a single
// synchronous BRAM port, one transfer at a time.
//
// Handshake: a requester raises req with its address/data and holds them
// stable until it sees ack (a one-cycle pulse). It drops req on the edge
// that ends the ack cycle; a req still high in the following IDLE cycle is
// taken as a new request. Load data is valid in the ack cycle and is held
// until that port's next load completes.
module bram_responder
  import bram_resp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_ack,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output state_t            dbg_state
);

  state_t     state_q, state_d;
  logic [1:0] lat_q;
  logic       req_port_q;
  logic       req_we_q;
  logic       grant_valid;
  logic       grant_port;
  logic       launch;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_cpu     (cpu_req),
    .req_vid     (vid_req),
    .update      (state_q == ST_ACK),
    .upd_port    (req_port_q),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  assign launch    = (state_q == ST_IDLE) && grant_valid;
  assign dbg_state = state_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and acknowledge decode
  always_comb begin
    state_d = state_q;
    cpu_ack = 1'b0;
    vid_ack = 1'b0;
    case (state_q)
      ST_IDLE:  if (grant_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = req_we_q ? ST_ACK : ST_WAIT;
      ST_WAIT:  if (lat_q == 2'd0) state_d = ST_ACK;
      ST_ACK: begin
        state_d = ST_IDLE;
        cpu_ack = (req_port_q == PORT_CPU);
        vid_ack = (req_port_q == PORT_VID);
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latch and registered BRAM drive; bram_addr/bram_wdata double
  // as the latched request so later input changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_port_q <= PORT_CPU;
      req_we_q   <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      bram_en <= launch;
      bram_we <= launch && (grant_port == PORT_CPU) && cpu_we;
      if (launch) begin
        req_port_q <= grant_port;
        req_we_q   <= (grant_port == PORT_CPU) ? cpu_we : 1'b0;
        bram_addr  <= (grant_port == PORT_CPU) ? cpu_addr : vid_addr;
        bram_wdata <= (grant_port == PORT_CPU) ? cpu_wdata : '0;
      end
    end
  end

  // Read latency countdown: loaded in ISSUE, reaches zero in the last WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_q <= 2'd0;
    end else if (state_q == ST_ISSUE) begin
      lat_q <= 2'(RD_LAT - 1);
    end else if ((state_q == ST_WAIT) && (lat_q != 2'd0)) begin
      lat_q <= lat_q - 2'd1;
    end
  end

  // Read-data capture into the granted port's holding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata <= '0;
      vid_rdata <= '0;
    end else if ((state_q == ST_WAIT) && (lat_q == 2'd0)) begin
      if (req_port_q == PORT_CPU) begin
        cpu_rdata <= bram_rdata;
      end else begin
        vid_rdata <= bram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bram_responder.sv
// Bench for bram_responder: directed vector table, multi-cycle corner
// sequences, and randomized two-port traffic against a memory model.
module tb_bram_responder;
  import bram_resp_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int N_RAND = 30;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT0 (RD_LAT=2) ----------------
  logic          cpu_req = 0, cpu_we = 0, vid_req = 0;
  logic [AW-1:0] cpu_addr = '0, vid_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata, vid_rdata, bram_wdata, bram_rdata;
  logic          cpu_ack, vid_ack, bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  state_t        dbg_state;

  bram_responder #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
    .vid_ack(vid_ack), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata), .dbg_state(dbg_state)
  );

  // ---------------- DUT1 (RD_LAT=1) ----------------
  logic          cpu_req1 = 0, cpu_we1 = 0, vid_req1 = 0;
  logic [AW-1:0] cpu_addr1 = '0, vid_addr1 = '0;
  logic [DW-1:0] cpu_wdata1 = '0;
  logic [DW-1:0] cpu_rdata1, vid_rdata1, bram_wdata1, bram_rdata1;
  logic          cpu_ack1, vid_ack1, bram_en1, bram_we1;
  logic [AW-1:0] bram_addr1;
  state_t        dbg_state1;

  bram_responder #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1),
    .cpu_wdata(cpu_wdata1), .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1),
    .vid_req(vid_req1), .vid_addr(vid_addr1), .vid_rdata(vid_rdata1),
    .vid_ack(vid_ack1), .bram_en(bram_en1), .bram_we(bram_we1),
    .bram_addr(bram_addr1), .bram_wdata(bram_wdata1),
    .bram_rdata(bram_rdata1), .dbg_state(dbg_state1)
  );

  // ---------------- BRAM models ----------------
  function automatic logic [DW-1:0] init_val(input int a);
    return 16'(a * 37 + 5);
  endfunction

  logic [DW-1:0] mem0 [0:1023];
  bit            wr0  [0:1023];
  logic [DW-1:0] rd_pipe0 = '0;
  logic [DW-1:0] mem1 [0:1023];
  bit            wr1  [0:1023];

  // Two-stage read pipe: data appears two cycles after the enable cycle
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        mem0[bram_addr] <= bram_wdata;
        wr0[bram_addr]  <= 1'b1;
      end else begin
        rd_pipe0 <= wr0[bram_addr] ? mem0[bram_addr] : init_val(int'(bram_addr));
      end
    end
    bram_rdata <= rd_pipe0;
  end

  // Single-stage read: data appears one cycle after the enable cycle
  always @(posedge clk) begin
    if (bram_en1) begin
      if (bram_we1) begin
        mem1[bram_addr1] <= bram_wdata1;
        wr1[bram_addr1]  <= 1'b1;
      end else begin
        bram_rdata1 <= wr1[bram_addr1] ? mem1[bram_addr1] : init_val(int'(bram_addr1));
      end
    end
  end

  // ---------------- scoreboard / reference ----------------
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [0:0]    exp_port_q[$];
  logic [DW-1:0] ref_mem [int];
  bit            rand_on = 0;
  int            rand_acks = 0;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(int'(a));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Random-phase monitor: serialised transfers mean the memory image at ack
  // time is exactly what any load must return
  always @(negedge clk) begin
    if (rand_on) begin
      if (cpu_ack) begin
        rand_acks++;
        chk("rand_ack_excl", 32'(vid_ack), 32'd0);
        if (cpu_we) ref_mem[int'(cpu_addr)] = cpu_wdata;
        else chk("rand_cpu_load", 32'(cpu_rdata), 32'(ref_read(cpu_addr)));
      end
      if (vid_ack) begin
        rand_acks++;
        chk("rand_vid_load", 32'(vid_rdata), 32'(ref_read(vid_addr)));
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    int            lat;
    bit            other;
    logic          en1, we1, en2, ack_after;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1, crd, vrd;
  } obs_t;

  // One transfer on DUT0; cycle 0 is the cycle req is first presented
  task automatic do_xfer(input bit is_vid, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, output obs_t o);
    o = '{lat: -1, other: 0, en1: 0, we1: 0, en2: 0, ack_after: 0,
          a1: '0, d1: '0, crd: '0, vrd: '0};
    @(posedge clk); #1;
    if (is_vid) begin
      vid_req = 1; vid_addr = addr;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        o.en1 = bram_en; o.we1 = bram_we; o.a1 = bram_addr; o.d1 = bram_wdata;
      end
      if (c == 2) o.en2 = bram_en;
      if (is_vid ? cpu_ack : vid_ack) o.other = 1;
      if (is_vid ? vid_ack : cpu_ack) begin
        o.lat = c; o.crd = cpu_rdata; o.vrd = vid_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    if (is_vid) vid_req = 0; else cpu_req = 0;
    @(negedge clk);
    o.ack_after = is_vid ? vid_ack : cpu_ack;
  endtask

  // One transfer on DUT1
  task automatic xfer1(input bit is_vid, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, output int lat, output logic [DW-1:0] rd);
    lat = -1; rd = '0;
    @(posedge clk); #1;
    if (is_vid) begin
      vid_req1 = 1; vid_addr1 = addr;
    end else begin
      cpu_req1 = 1; cpu_we1 = we; cpu_addr1 = addr; cpu_wdata1 = wdata;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (is_vid ? vid_ack1 : cpu_ack1) begin
        lat = c; rd = is_vid ? vid_rdata1 : cpu_rdata1;
        break;
      end
    end
    @(posedge clk); #1;
    if (is_vid) vid_req1 = 0; else cpu_req1 = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            is_vid;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            exp_lat;
    logic [DW-1:0] exp_crd;
    logic [DW-1:0] exp_vrd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    obs_t o;
    int   n, lat1;
    bit   prev;
    logic [DW-1:0] rd1;

    vecs[0] = '{0, 1, 10'h005, 16'hBEEF, 2, 16'h0000, 16'h0000};
    vecs[1] = '{0, 0, 10'h005, 16'h0000, 4, 16'hBEEF, 16'h0000};
    vecs[2] = '{1, 0, 10'h005, 16'h0000, 4, 16'hBEEF, 16'hBEEF};
    vecs[3] = '{0, 1, 10'h010, 16'h1234, 2, 16'hBEEF, 16'hBEEF};
    vecs[4] = '{1, 0, 10'h010, 16'h0000, 4, 16'hBEEF, 16'h1234};
    vecs[5] = '{0, 1, 10'h3FF, 16'hA5A5, 2, 16'hBEEF, 16'h1234};
    vecs[6] = '{0, 0, 10'h3FF, 16'h0000, 4, 16'hA5A5, 16'h1234};
    vecs[7] = '{0, 1, 10'h000, 16'h0001, 2, 16'hA5A5, 16'h1234};
    vecs[8] = '{0, 0, 10'h000, 16'h0000, 4, 16'h0001, 16'h1234};
    vecs[9] = '{1, 0, 10'h001, 16'h0000, 4, 16'h0001, 16'h002A};

    // ---- reset values ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_vid_ack", 32'(vid_ack), 0);
    chk("rst_bram_en", 32'(bram_en), 0);
    chk("rst_bram_we", 32'(bram_we), 0);
    chk("rst_bram_addr", 32'(bram_addr), 0);
    chk("rst_bram_wdata", 32'(bram_wdata), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_vid_rdata", 32'(vid_rdata), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst1_bram_en", 32'(bram_en1), 0);
    chk("rst1_vid_rdata", 32'(vid_rdata1), 0);
    @(posedge clk); #1 reset = 0;

    // ---- directed single-port table ----
    foreach (vecs[i]) begin
      do_xfer(vecs[i].is_vid, vecs[i].we, vecs[i].addr, vecs[i].wdata, o);
      chk($sformatf("vec%0d_lat", i), 32'(o.lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_cpu_rdata", i), 32'(o.crd), 32'(vecs[i].exp_crd));
      chk($sformatf("vec%0d_vid_rdata", i), 32'(o.vrd), 32'(vecs[i].exp_vrd));
      chk($sformatf("vec%0d_issue_en", i), 32'(o.en1), 1);
      chk($sformatf("vec%0d_issue_we", i), 32'(o.we1), 32'(vecs[i].we));
      chk($sformatf("vec%0d_issue_addr", i), 32'(o.a1), 32'(vecs[i].addr));
      if (vecs[i].we) chk($sformatf("vec%0d_issue_wdata", i), 32'(o.d1), 32'(vecs[i].wdata));
      chk($sformatf("vec%0d_en_after_issue", i), 32'(o.en2), 0);
      chk($sformatf("vec%0d_other_ack", i), 32'(o.other), 0);
      chk($sformatf("vec%0d_ack_single", i), 32'(o.ack_after), 0);
    end

    // ---- reset during WAIT of a CPU load ----
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
    @(posedge clk);           // IDLE -> ISSUE
    @(posedge clk);           // ISSUE -> WAIT
    #2 reset = 1;
    #1;
    chk("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rstmid_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rstmid_vid_rdata", 32'(vid_rdata), 0);
    chk("rstmid_bram_en", 32'(bram_en), 0);
    chk("rstmid_bram_addr", 32'(bram_addr), 0);
    chk("rstmid_acks", 32'({cpu_ack, vid_ack}), 0);
    cpu_req = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_ack || vid_ack) n++;
    end
    chk("rstmid_no_ack", 32'(n), 0);

    // ---- contention: both held high, CPU first after reset ----
    exp_port_q = '{PORT_CPU, PORT_VID, PORT_CPU, PORT_VID};
    exp_q      = '{16'hBEEF, 16'h1234, 16'hBEEF, 16'h1234};
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
    vid_req = 1; vid_addr = 10'h010;
    n = 0; prev = 0;
    for (int c = 0; c < 80 && n < 4; c++) begin
      @(negedge clk);
      if (cpu_ack || vid_ack) begin
        chk("cont_ack_single", 32'(prev), 0);
        chk("cont_ack_excl", 32'(cpu_ack && vid_ack), 0);
        chk("cont_order", 32'(vid_ack), 32'(exp_port_q.pop_front()));
        chk("cont_data", 32'(vid_ack ? vid_rdata : cpu_rdata), 32'(exp_q.pop_front()));
        n++;
      end
      prev = cpu_ack || vid_ack;
    end
    chk("cont_count", 32'(n), 4);
    @(posedge clk); #1;
    cpu_req = 0; vid_req = 0;
    repeat (2) @(posedge clk);

    // ---- randomized two-port traffic ----
    rand_on = 1;
    fork
      begin
        obs_t oc;
        for (int k = 0; k < N_RAND; k++) begin
          do_xfer(0, 1'($urandom_range(0, 1)), 10'(10'h020 + $urandom_range(0, 15)),
                  16'($urandom), oc);
          chk("rand_cpu_wait_bound", 32'(oc.lat >= 0 && oc.lat <= 9), 1);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
      begin
        obs_t ov;
        for (int k = 0; k < N_RAND; k++) begin
          do_xfer(1, 0, 10'(10'h020 + $urandom_range(0, 15)), '0, ov);
          chk("rand_vid_wait_bound", 32'(ov.lat >= 0 && ov.lat <= 9), 1);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
    join
    repeat (3) @(posedge clk);
    rand_on = 0;
    chk("rand_ack_count", 32'(rand_acks), 32'(2 * N_RAND));

    // ---- RD_LAT=1 build ----
    xfer1(0, 1, 10'h3FF, 16'hA5A5, lat1, rd1);
    chk("lat1_store_lat", 32'(lat1), 2);
    xfer1(1, 0, 10'h3FF, 16'h0000, lat1, rd1);
    chk("lat1_vid_lat", 32'(lat1), 3);
    chk("lat1_vid_rdata", 32'(rd1), 32'h0000A5A5);
    xfer1(0, 0, 10'h3FF, 16'h0000, lat1, rd1);
    chk("lat1_cpu_lat", 32'(lat1), 3);
    chk("lat1_cpu_rdata", 32'(rd1), 32'h0000A5A5);

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_responder.md
# bram_responder

Memory-side responder that services load/store requests issued by the CPU control FSM and read requests from the display/game logic. It arbitrates between the two ports and drives a single synchronous BRAM port. It returns a one-cycle acknowledge (with read data for loads) to each requester. It sits between the CPU datapath, the display fetch logic, and the game-state BRAM.

## Interface
- DATA_W, 16, data width of BRAM words
- ADDR_W, 10, BRAM word-address width
- RD_LAT, 2, BRAM read latency in cycles (legal: 1 or 2)

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU request; held high until cpu_ack
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data; valid in the cpu_ack cycle and held until the next CPU load completes
- cpu_ack  out  1  one-cycle completion pulse
- vid_req  in  1  display read request; held high until vid_ack
- vid_addr  in  ADDR_W  display word address
- vid_rdata  out  DATA_W  read data; valid in the vid_ack cycle and held until the next display read completes
- vid_ack  out  1  one-cycle completion pulse
- bram_en  out  1  BRAM port enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_wdata  out  DATA_W  BRAM write data
- bram_rdata  in  DATA_W  BRAM read data, valid RD_LAT cycles after the enable cycle

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - Samples cpu_req and vid_req.
  - If exactly one is high, that port is granted.
  - If both are high, the port not granted last time wins. The last_grant flag resets to "video", so the CPU wins the first tie.
  - The granted port's address, we (0 for video) and wdata are latched into request registers on the IDLE->ISSUE edge. Later changes on the inputs are ignored.
- **ISSUE** (1 cycle)
  - bram_en = 1; bram_we = latched we; bram_addr/bram_wdata come from the latched registers.
  - A write goes to ACK. A read goes to WAIT.
- **WAIT** (RD_LAT cycles)
  - A latency counter counts down.
  - On the last WAIT cycle's edge, bram_rdata is captured into the granted port's rdata register.
- **ACK** (1 cycle)
  - The granted port's ack = 1; the other ack stays 0.
  - last_grant is updated.
  - The next state is IDLE unconditionally, and request inputs are ignored during ACK.
- **Requester rule:** a requester must drop req on the edge where it sees ack. A req still high in the following IDLE cycle is treated as a new request.
- **Ungranted port:** a requester that is not granted simply keeps req high. There is no timeout and no starvation, because tie-breaking alternates.
- **Reset mid-operation:** the outstanding transfer is abandoned with no ack. A write already in ISSUE may have reached BRAM. The requester re-issues after reset.

## Timing
- **Reset values:** all outputs are 0 (acks, bram_en, bram_we, bram_addr, bram_wdata, cpu_rdata, vid_rdata). State = IDLE, last_grant = video, latency counter = 0.
- bram_* outputs are registered. bram_en and bram_we are high only in the ISSUE cycle.
- Cycle numbering: cycle 0 is the IDLE cycle in which req is sampled high.
  - Store: ISSUE in cycle 1, ack in cycle 2. Req-to-ack latency is 2.
  - Load: ISSUE in cycle 1, WAIT in cycles 2..1+RD_LAT, ack in cycle 2+RD_LAT. Latency is 4 for RD_LAT=2 and 3 for RD_LAT=1.
- Back-to-back transfers: the earliest next ISSUE is 2 cycles after an ack (ack, then IDLE, then ISSUE).
- The rdata registers update only on their own port's read capture. A write never changes cpu_rdata.

## Structure
- Shared package bram_resp_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/ACK);
  - default DATA_W and ADDR_W;
  - the port-select encoding (PORT_CPU = 0, PORT_VID = 1).
- Sub-module rr_arbiter2 provides the two-request round-robin grant with a last_grant register, updated on an update strobe asserted in ACK.
- The FSM, request latches, latency counter and rdata registers live in the top module.

## Test plan
- **Reset:** assert reset mid-run -> all outputs 0 asynchronously. After release, simultaneous cpu_req/vid_req -> CPU granted first.
- **CPU store:** cpu_we=1, addr 0x005, wdata 0xBEEF -> bram_en=bram_we=1 with addr 0x005/data 0xBEEF in cycle 1; cpu_ack in cycle 2; vid_ack stays 0.
- **CPU load (RD_LAT=2):** load addr 0x005 with BRAM model returning 0xBEEF -> cpu_ack in cycle 4 with cpu_rdata=0xBEEF; cpu_rdata stays 0xBEEF through a later store.
- **Contention:** cpu_req and vid_req held continuously (video reads addr 0x010 = 0x1234) -> grants alternate CPU, VID, CPU, VID, and each ack is a single cycle.
- **Reset mid-read:** reset asserted during WAIT -> no ack is ever produced for that request; a re-issued load completes normally with correct data.
- **RD_LAT=1 build:** video load of addr 0x3FF returning 0xA5A5 -> vid_ack in cycle 3 with vid_rdata=0xA5A5.
